// File: rtl/moore_11011_overlapping.sv
// moore_11011_overlapping: Moore detector flagging every 11011 on serial input n, overlaps included
module moore_11011_overlapping (
    input  logic clk,
    input  logic rst,
    input  logic n,
    output logic d
);
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_t;
    state_t state, nxt;
    // state register, cleared to S0 as soon as rst rises
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S0;
        else     state <= nxt;
    // next state tracks the longest suffix that is a prefix of 11011; d decodes S5 only
    always_comb begin
        nxt = S0;
        d   = 1'b0;
        case (state)
            S0: nxt = n ? S1 : S0;
            S1: nxt = n ? S2 : S0;
            S2: nxt = n ? S2 : S3;
            S3: nxt = n ? S4 : S0;
            S4: nxt = n ? S5 : S0;
            S5: begin
                nxt = n ? S2 : S3;
                d   = 1'b1;
            end
            default: nxt = S0;
        endcase
    end
endmodule

// File: tb/tb_moore_11011_overlapping.sv
// tb_moore_11011_overlapping: directed plus random checks of the 11011 detector against a bit-history model
module tb_moore_11011_overlapping;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic n = 1'b0;
    logic d;
    int checks = 0;
    int failures = 0;
    logic [4:0] hist = 5'b0;

    moore_11011_overlapping dut (.clk(clk), .rst(rst), .n(n), .d(d));

    // free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic exp);
        checks++;
        assert (d === exp) else begin
            failures++;
            $error("FAIL %s d=%b expected=%b", tag, d, exp);
        end
    endtask

    // model: the last five bits since reset must read 11011 exactly
    task automatic step(input logic b, input string tag);
        n = b;
        @(posedge clk);
        #1;
        hist = rst ? 5'b0 : {hist[3:0], b};
        chk(tag, !rst && hist == 5'b11011);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, "reset_hold");
        step(1'b1, "reset_hold");
        rst = 1'b0;
    endtask

    task automatic stream(input string tag, input logic [15:0] s, input int len);
        for (int i = len - 1; i >= 0; i--) step(s[i], tag);
    endtask

    initial begin
        do_reset();
        stream("reset_then_match", 16'b110110, 6);
        do_reset();
        stream("overlap", 16'b11011011, 8);
        do_reset();
        stream("long_ones", 16'b1111011, 7);
        do_reset();
        stream("near_miss", 16'b1101011011, 10);
        do_reset();
        stream("pre_async", 16'b11011, 5);
        #3 rst = 1'b1;
        #1 hist = 5'b0;
        chk("async_drop", 1'b0);
        #1 rst = 1'b0;
        stream("after_async", 16'b11, 2);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, "idle_zeros");
        for (int i = 0; i < 20; i++) step(1'b1, "idle_ones");
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #1 hist = 5'b0;
                chk("rand_async", 1'b0);
                #1 rst = 1'b0;
            end else begin
                step(($urandom % 4) != 0, "random");
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
